// File: rtl/free_list_pkg.sv
// Shared constants and helpers for the physical register free list.
// PREG_COUNT / ARCH_COUNT / TAG_W defaults are the rename-stage sizing used by
// rename and issue logic; the free list takes them as parameter defaults.
package free_list_pkg;

    localparam int DEF_PREG_COUNT = 64;
    localparam int DEF_ARCH_COUNT = 16;
    localparam int DEF_TAG_W      = $clog2(DEF_PREG_COUNT);
    localparam int N_SLOTS        = 3;

    // Number of set bits in a 3-bit slot mask.
    function automatic logic [1:0] popcount3(input logic [2:0] mask);
        return 2'({1'b0, mask[0]} + {1'b0, mask[1]} + {1'b0, mask[2]});
    endfunction

endpackage

// File: rtl/free_list_prefix_count3.sv
// Exclusive prefix popcount of a 3-bit slot mask: prefix_o[i] is the number of
// set bits below slot i. Used to compact sparse alloc/free masks.
module prefix_count3
    import free_list_pkg::*;
(
    input  logic [2:0]      mask_i,
    output logic [2:0][1:0] prefix_o,
    output logic [1:0]      total_o
);

    // Ripple the running count across the three slots.
    always_comb begin
        prefix_o[0] = 2'd0;
        prefix_o[1] = {1'b0, mask_i[0]};
        prefix_o[2] = 2'({1'b0, mask_i[0]} + {1'b0, mask_i[1]});
        total_o     = popcount3(mask_i);
    end

endmodule

// File: rtl/free_list.sv
// Physical register free list: circular buffer of free tags, up to three
// grants and three returns per cycle. Freed tags land behind the tail and are
// never bypassed to a same-cycle grant.
// Optional checking is enabled with the FREE_LIST_CHECK_EN macro; without it
// error_o is tied low.
module free_list
    import free_list_pkg::*;
#(
    parameter int PREG_COUNT = DEF_PREG_COUNT,
    parameter int ARCH_COUNT = DEF_ARCH_COUNT,
    parameter int TAG_W      = DEF_TAG_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            alloc_req_i,
    output logic                  alloc_ready_o,
    output logic [2:0][TAG_W-1:0] alloc_tags_o,
    input  logic [2:0]            free_valid_i,
    input  logic [2:0][TAG_W-1:0] free_tags_i,
    output logic [TAG_W:0]        count_o,
    output logic                  error_o
);

    localparam int INIT_FREE = PREG_COUNT - ARCH_COUNT;

    logic [TAG_W-1:0] mem_q [PREG_COUNT];
    logic [TAG_W-1:0] mem_d [PREG_COUNT];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    logic [2:0][1:0]  alloc_pfx;
    logic [2:0][1:0]  free_pfx;
    logic [1:0]       n_req;
    logic [1:0]       n_free;
    logic             fire;
    logic [TAG_W-1:0] rd_addr [N_SLOTS];
    logic [TAG_W-1:0] wr_addr [N_SLOTS];

    prefix_count3 u_alloc_pfx (
        .mask_i   (alloc_req_i),
        .prefix_o (alloc_pfx),
        .total_o  (n_req)
    );

    prefix_count3 u_free_pfx (
        .mask_i   (free_valid_i),
        .prefix_o (free_pfx),
        .total_o  (n_free)
    );

    // Grant path: readiness and compacted candidate tags from registered state.
    always_comb begin
        alloc_ready_o = (count_q >= (TAG_W+1)'(n_req));
        fire          = alloc_ready_o && (n_req != 2'd0);
        alloc_tags_o  = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            rd_addr[i] = head_q + TAG_W'(alloc_pfx[i]);
            if (alloc_req_i[i]) begin
                alloc_tags_o[i] = mem_q[rd_addr[i]];
            end
        end
    end

    // Next state: write returned tags behind the tail, advance pointers and count.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < N_SLOTS; i++) begin
            wr_addr[i] = tail_q + TAG_W'(free_pfx[i]);
            if (free_valid_i[i]) begin
                mem_d[wr_addr[i]] = free_tags_i[i];
            end
        end
        head_d  = fire ? head_q + TAG_W'(n_req) : head_q;
        tail_d  = tail_q + TAG_W'(n_free);
        count_d = count_q - (fire ? (TAG_W+1)'(n_req) : '0) + (TAG_W+1)'(n_free);
    end

    // State registers; reset loads tags ARCH_COUNT.. into the list in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < PREG_COUNT; k++) begin
                mem_q[k] <= (k < INIT_FREE) ? TAG_W'(ARCH_COUNT + k) : '0;
            end
            head_q  <= '0;
            tail_q  <= TAG_W'(INIT_FREE);
            count_q <= (TAG_W+1)'(INIT_FREE);
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

`ifdef FREE_LIST_CHECK_EN
    localparam int ARCH_W = $clog2(ARCH_COUNT);

    logic [PREG_COUNT-1:0] is_free_q, is_free_d;
    logic [ARCH_COUNT-1:0] arch_used_q, arch_used_d;
    logic                  error_q, error_d;
    logic                  err_now;

    // Track which tags are free and flag illegal returns; does not alter the datapath.
    always_comb begin
        is_free_d   = is_free_q;
        arch_used_d = arch_used_q;
        err_now     = 1'b0;
        if (fire) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (alloc_req_i[i]) begin
                    is_free_d[alloc_tags_o[i]] = 1'b0;
                    if (alloc_tags_o[i] < TAG_W'(ARCH_COUNT)) begin
                        arch_used_d[alloc_tags_o[i][ARCH_W-1:0]] = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < N_SLOTS; i++) begin
            if (free_valid_i[i]) begin
                if (is_free_q[free_tags_i[i]]) begin
                    err_now = 1'b1;
                end
                if ((free_tags_i[i] < TAG_W'(ARCH_COUNT)) &&
                    !arch_used_q[free_tags_i[i][ARCH_W-1:0]]) begin
                    err_now = 1'b1;
                end
                is_free_d[free_tags_i[i]] = 1'b1;
            end
        end
        for (int i = 0; i < N_SLOTS; i++) begin
            for (int j = i + 1; j < N_SLOTS; j++) begin
                if (free_valid_i[i] && free_valid_i[j] &&
                    (free_tags_i[i] == free_tags_i[j])) begin
                    err_now = 1'b1;
                end
            end
        end
        if (count_d > (TAG_W+1)'(INIT_FREE)) begin
            err_now = 1'b1;
        end
        error_d = error_q | err_now;
    end

    // Checker state; error is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_free_q   <= {{INIT_FREE{1'b1}}, {ARCH_COUNT{1'b0}}};
            arch_used_q <= '0;
            error_q     <= 1'b0;
        end else begin
            is_free_q   <= is_free_d;
            arch_used_q <= arch_used_d;
            error_q     <= error_d;
        end
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list. The reference model is a FIFO queue of
// free tags plus a pool of tags currently held by rename.
module tb_free_list;

    localparam int TW = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic [2:0]         alloc_req_i;
    logic               alloc_ready_o;
    logic [2:0][TW-1:0] alloc_tags_o;
    logic [2:0]         free_valid_i;
    logic [2:0][TW-1:0] free_tags_i;
    logic [TW:0]        count_o;
    logic               error_o;

    int n_cmp = 0;
    int n_mis = 0;
    int fq[$];
    int live[$];

    free_list dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_req_i   (alloc_req_i),
        .alloc_ready_o (alloc_ready_o),
        .alloc_tags_o  (alloc_tags_o),
        .free_valid_i  (free_valid_i),
        .free_tags_i   (free_tags_i),
        .count_o       (count_o),
        .error_o       (error_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [2:0] req, input logic [2:0] fv,
                         input int t0, input int t1, input int t2);
        alloc_req_i    = req;
        free_valid_i   = fv;
        free_tags_i[0] = TW'(t0);
        free_tags_i[1] = TW'(t1);
        free_tags_i[2] = TW'(t2);
        #1;
    endtask

    // One clock edge; the model consumes the inputs that were applied.
    task automatic tick();
        logic [2:0] req;
        logic [2:0] fv;
        int         tags[3];
        int         nreq;
        bit         r;
        req  = alloc_req_i;
        fv   = free_valid_i;
        r    = rst;
        for (int i = 0; i < 3; i++) tags[i] = int'(free_tags_i[i]);
        nreq = $countones(req);
        @(posedge clk);
        #1;
        if (r) begin
            fq.delete();
            live.delete();
            for (int k = 16; k < 64; k++) fq.push_back(k);
        end else begin
            if (nreq > 0 && fq.size() >= nreq) begin
                for (int i = 0; i < nreq; i++) live.push_back(fq.pop_front());
            end
            for (int i = 0; i < 3; i++) if (fv[i]) fq.push_back(tags[i]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(3'b000, 3'b000, 0, 0, 0);
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (count_o !== 7'd48) begin
            n_mis++; $display("FAIL reset_count: got %0d exp 48", count_o);
        end
        n_cmp++;
        if (error_o !== 1'b0) begin
            n_mis++; $display("FAIL reset_error: got %0b exp 0", error_o);
        end
        n_cmp++;
        if (alloc_ready_o !== 1'b1 || alloc_tags_o !== '0) begin
            n_mis++; $display("FAIL reset_idle: ready %0b tags %h exp 1/0", alloc_ready_o, alloc_tags_o);
        end
    endtask

    task automatic test_alloc_full();
        do_reset();
        drive(3'b111, 3'b000, 0, 0, 0);
        n_cmp++;
        if (alloc_ready_o !== 1'b1 || alloc_tags_o[0] !== 6'd16 ||
            alloc_tags_o[1] !== 6'd17 || alloc_tags_o[2] !== 6'd18) begin
            n_mis++; $display("FAIL alloc_full: ready %0b tags %0d %0d %0d exp 1 16 17 18",
                              alloc_ready_o, alloc_tags_o[0], alloc_tags_o[1], alloc_tags_o[2]);
        end
        tick();
        drive(3'b000, 3'b000, 0, 0, 0);
        n_cmp++;
        if (count_o !== 7'd45) begin
            n_mis++; $display("FAIL alloc_full_count: got %0d exp 45", count_o);
        end
    endtask

    task automatic test_alloc_sparse();
        do_reset();
        drive(3'b101, 3'b000, 0, 0, 0);
        n_cmp++;
        if (alloc_tags_o[0] !== 6'd16 || alloc_tags_o[1] !== 6'd0 || alloc_tags_o[2] !== 6'd17) begin
            n_mis++; $display("FAIL alloc_sparse: tags %0d %0d %0d exp 16 0 17",
                              alloc_tags_o[0], alloc_tags_o[1], alloc_tags_o[2]);
        end
        tick();
        drive(3'b000, 3'b000, 0, 0, 0);
        n_cmp++;
        if (count_o !== 7'd46) begin
            n_mis++; $display("FAIL alloc_sparse_count: got %0d exp 46", count_o);
        end
    endtask

    task automatic test_drain_stall();
        do_reset();
        for (int r = 0; r < 15; r++) begin
            drive(3'b111, 3'b000, 0, 0, 0);
            tick();
        end
        drive(3'b001, 3'b000, 0, 0, 0);
        tick();
        drive(3'b111, 3'b001, 5, 0, 0);
        n_cmp++;
        if (count_o !== 7'd2 || alloc_ready_o !== 1'b0) begin
            n_mis++; $display("FAIL drain_stall: count %0d ready %0b exp 2/0", count_o, alloc_ready_o);
        end
        tick();
        drive(3'b111, 3'b000, 0, 0, 0);
        n_cmp++;
        if (count_o !== 7'd3 || alloc_ready_o !== 1'b1) begin
            n_mis++; $display("FAIL drain_refill: count %0d ready %0b exp 3/1", count_o, alloc_ready_o);
        end
        n_cmp++;
        if (alloc_tags_o[0] !== 6'd62 || alloc_tags_o[1] !== 6'd63 || alloc_tags_o[2] !== 6'd5) begin
            n_mis++; $display("FAIL drain_tags: tags %0d %0d %0d exp 62 63 5",
                              alloc_tags_o[0], alloc_tags_o[1], alloc_tags_o[2]);
        end
        tick();
        drive(3'b000, 3'b000, 0, 0, 0);
        n_cmp++;
        if (count_o !== 7'd0) begin
            n_mis++; $display("FAIL drain_empty: got %0d exp 0", count_o);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int r = 0; r < 16; r++) begin
            drive(3'b111, 3'b000, 0, 0, 0);
            tick();
        end
        for (int r = 0; r < 20; r++) begin
            drive(3'b000, 3'b111, 16, 17, 18);
            tick();
            drive(3'b111, 3'b000, 0, 0, 0);
            n_cmp++;
            if (count_o !== 7'd3 || alloc_ready_o !== 1'b1 || alloc_tags_o[0] !== 6'd16 ||
                alloc_tags_o[1] !== 6'd17 || alloc_tags_o[2] !== 6'd18) begin
                n_mis++; $display("FAIL wrap_rep%0d: count %0d ready %0b tags %0d %0d %0d exp 3 1 16 17 18",
                                  r, count_o, alloc_ready_o, alloc_tags_o[0], alloc_tags_o[1], alloc_tags_o[2]);
            end
            tick();
        end
        drive(3'b000, 3'b000, 0, 0, 0);
        n_cmp++;
        if (count_o !== 7'd0) begin
            n_mis++; $display("FAIL wrap_end_count: got %0d exp 0", count_o);
        end
    endtask

    task automatic test_simul();
        do_reset();
        drive(3'b011, 3'b011, 40, 41, 0);
        n_cmp++;
        if (alloc_tags_o[0] !== 6'd16 || alloc_tags_o[1] !== 6'd17 || alloc_tags_o[2] !== 6'd0) begin
            n_mis++; $display("FAIL simul_tags: tags %0d %0d %0d exp 16 17 0",
                              alloc_tags_o[0], alloc_tags_o[1], alloc_tags_o[2]);
        end
        tick();
        drive(3'b000, 3'b000, 0, 0, 0);
        n_cmp++;
        if (count_o !== 7'd48) begin
            n_mis++; $display("FAIL simul_count: got %0d exp 48", count_o);
        end
    endtask

    task automatic test_random();
        logic [2:0] req;
        logic [2:0] fv;
        int         t[3];
        int         nreq;
        int         pfx;
        int         idx;
        bit         rdy;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req = 3'($urandom_range(0, 7));
            fv  = 3'b000;
            for (int i = 0; i < 3; i++) begin
                t[i] = $urandom_range(0, 63);
                if (live.size() > 0 && $urandom_range(0, 1) == 1) begin
                    idx   = $urandom_range(0, live.size() - 1);
                    t[i]  = live[idx];
                    live.delete(idx);
                    fv[i] = 1'b1;
                end
            end
            drive(req, fv, t[0], t[1], t[2]);
            nreq = $countones(req);
            rdy  = (fq.size() >= nreq);
            n_cmp++;
            if (alloc_ready_o !== rdy) begin
                n_mis++; $display("FAIL rand_ready c%0d: got %0b exp %0b", c, alloc_ready_o, rdy);
            end
            pfx = 0;
            for (int i = 0; i < 3; i++) begin
                if (!req[i]) begin
                    n_cmp++;
                    if (alloc_tags_o[i] !== '0) begin
                        n_mis++; $display("FAIL rand_idle_tag c%0d s%0d: got %0d exp 0", c, i, alloc_tags_o[i]);
                    end
                end else begin
                    if (rdy) begin
                        n_cmp++;
                        if (alloc_tags_o[i] !== TW'(fq[pfx])) begin
                            n_mis++; $display("FAIL rand_tag c%0d s%0d: got %0d exp %0d", c, i, alloc_tags_o[i], fq[pfx]);
                        end
                    end
                    pfx++;
                end
            end
            tick();
            n_cmp++;
            if (int'(count_o) != fq.size()) begin
                n_mis++; $display("FAIL rand_count c%0d: got %0d exp %0d", c, count_o, fq.size());
            end
        end
        drive(3'b000, 3'b000, 0, 0, 0);
    endtask

    task automatic test_error();
        logic exp_err;
`ifdef FREE_LIST_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        drive(3'b000, 3'b001, 20, 0, 0);
        tick();
        drive(3'b000, 3'b000, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (error_o !== exp_err) begin
                n_mis++; $display("FAIL error_hold c%0d: got %0b exp %0b", c, error_o, exp_err);
            end
            tick();
        end
        do_reset();
        n_cmp++;
        if (error_o !== 1'b0) begin
            n_mis++; $display("FAIL error_cleared: got %0b exp 0", error_o);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(3'b000, 3'b000, 0, 0, 0);
        @(posedge clk);
        #1;
        test_reset();
        test_alloc_full();
        test_alloc_sparse();
        test_drain_stall();
        test_wrap();
        test_simul();
        test_random();
        test_error();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
